// File: rtl/io_pad_stage.sv
// io_pad_stage: conditions Caravel user IO between the pads and the core.
// Inbound pins are synchronised into wb_clk_i (the low FILT_PINS pins are
// also glitch-filtered). Outbound data/enables are registered and held
// tristated for RELEASE_CYCLES cycles after reset.
module io_pad_stage #(
  parameter int NPINS          = 38,
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_PINS      = 8,
  parameter int FILT_CYCLES    = 4,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic                                         wb_clk_i,
  input  logic                                         wb_rst_i,
  input  logic [NPINS-1:0]                             pad_io_in,
  output logic [NPINS-1:0]                             core_io_in,
  input  logic [NPINS-1:0]                             core_io_out,
  input  logic [NPINS-1:0]                             core_io_oeb,
  output logic [NPINS-1:0]                             pad_io_out,
  output logic [NPINS-1:0]                             pad_io_oeb,
  output logic [((FILT_PINS > 0) ? FILT_PINS : 1)-1:0] filt_edge,
  output logic                                         released
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(FILT_CYCLES - 1);
  localparam logic [RW-1:0] REL_LAST  = RW'(RELEASE_CYCLES - 1);

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------
  logic [NPINS-1:0] sync_q [SYNC_STAGES];
  logic [NPINS-1:0] synced;

  // Shift every pad through SYNC_STAGES flops; stage 0 is the only one
  // allowed to go metastable.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      // NOTE: the sync chain is flops, not RAM, so every entry is cleared
      // in the reset branch; a real memory array would be left unreset.
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value; blocking here would collapse the chain to one flop.
      sync_q[0] <= pad_io_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Glitch filter on pins [FILT_PINS-1:0]
  // ---------------------------------------------------------------------
  generate
    if (FILT_PINS > 0) begin : g_filt
      logic [FILT_PINS-1:0] filt_val;
      logic [FILT_PINS-1:0] edge_val;

      for (genvar i = 0; i < FILT_PINS; i++) begin : g_pin
        logic [CW-1:0] cnt_q;
        logic          f_q;
        logic          edge_q;

        // Count consecutive cycles the synced value disagrees with the
        // filtered value; adopt it after FILT_CYCLES, restart on any bounce.
        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
          if (wb_rst_i) begin
            cnt_q  <= '0;
            f_q    <= 1'b0;
            edge_q <= 1'b0;
          end else begin
            edge_q <= 1'b0;
            if (synced[i] == f_q) begin
              cnt_q <= '0;
            end else if (cnt_q == FILT_LAST) begin
              f_q    <= synced[i];
              cnt_q  <= '0;
              edge_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end

        assign filt_val[i] = f_q;
        assign edge_val[i] = edge_q;
      end

      assign filt_edge = edge_val;
      if (FILT_PINS < NPINS) begin : g_mix
        assign core_io_in = {synced[NPINS-1:FILT_PINS], filt_val};
      end else begin : g_all
        assign core_io_in = filt_val;
      end
    end else begin : g_nofilt
      assign filt_edge  = 1'b0;
      assign core_io_in = synced;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Output release FSM
  // ---------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  // State and release-window counter registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= HOLD;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Count out the release window in HOLD, then move to RUN for good.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no
    // latch is inferred.
    state_d = state_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      HOLD: begin
        if (rcnt_q == REL_LAST) state_d = RUN;
        else                    rcnt_d  = rcnt_q + RW'(1);
      end
      RUN:     state_d = RUN;
      default: state_d = HOLD;
    endcase
  end

  // Register core outputs toward the pads; tristate everything until RUN.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pad_io_out <= '0;
      pad_io_oeb <= '1;
    end else if (state_q == RUN) begin
      pad_io_out <= core_io_out;
      pad_io_oeb <= core_io_oeb;
    end else begin
      pad_io_out <= '0;
      pad_io_oeb <= '1;
    end
  end

  assign released = (state_q == RUN);

endmodule
